// File: rtl/jt5205_multi.sv
// rtl/jt5205_multi.sv - multi-channel OKI ADPCM decoder with a shared time-multiplexed engine
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cen                  384 kHz chip clock enable (one clk wide)
//   sel[2*NCH]           per-channel rate select: 0 /96, 1 /64, 2 /48, 3 stop
//   din[4*NCH]           per-channel ADPCM nibble, written on din_valid & din_ready
//   din_valid/din_ready  per-channel nibble handshake (ready = FIFO not full, channel running)
//   ch_sound[12*NCH]     per-channel signed 12-bit decoded sample
//   sample[NCH]          one-clk strobe when the matching ch_sound slice updates
//   underrun[NCH]        sticky: a tick found the channel FIFO empty; cleared by clr_udr
//   mix[MIXW]            registered signed sum of all channels
//
// Build option: define JT5205_MIX_EN to build the mixer; otherwise mix is tied to 0.
module jt5205_multi #(
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int MIXW  = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic [2*NCH-1:0]    sel,
  input  logic [4*NCH-1:0]    din,
  input  logic [NCH-1:0]      din_valid,
  output logic [NCH-1:0]      din_ready,
  output logic [12*NCH-1:0]   ch_sound,
  output logic [NCH-1:0]      sample,
  output logic [NCH-1:0]      underrun,
  input  logic [NCH-1:0]      clr_udr,
  output logic [MIXW-1:0]     mix
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Last divider count for each rate select; the tick happens on that cen.
  function automatic logic [6:0] div_last(input logic [1:0] s);
    case (s)
      2'd0:    div_last = 7'd95;
      2'd1:    div_last = 7'd63;
      2'd2:    div_last = 7'd47;
      default: div_last = 7'd0;
    endcase
  endfunction

  function automatic logic [10:0] oki_step(input logic [5:0] i);
    case (i)
      6'd0:  oki_step = 11'd16;   6'd1:  oki_step = 11'd17;   6'd2:  oki_step = 11'd19;
      6'd3:  oki_step = 11'd21;   6'd4:  oki_step = 11'd23;   6'd5:  oki_step = 11'd25;
      6'd6:  oki_step = 11'd28;   6'd7:  oki_step = 11'd31;   6'd8:  oki_step = 11'd34;
      6'd9:  oki_step = 11'd37;   6'd10: oki_step = 11'd41;   6'd11: oki_step = 11'd45;
      6'd12: oki_step = 11'd50;   6'd13: oki_step = 11'd55;   6'd14: oki_step = 11'd60;
      6'd15: oki_step = 11'd66;   6'd16: oki_step = 11'd73;   6'd17: oki_step = 11'd80;
      6'd18: oki_step = 11'd88;   6'd19: oki_step = 11'd97;   6'd20: oki_step = 11'd107;
      6'd21: oki_step = 11'd118;  6'd22: oki_step = 11'd130;  6'd23: oki_step = 11'd143;
      6'd24: oki_step = 11'd157;  6'd25: oki_step = 11'd173;  6'd26: oki_step = 11'd190;
      6'd27: oki_step = 11'd209;  6'd28: oki_step = 11'd230;  6'd29: oki_step = 11'd253;
      6'd30: oki_step = 11'd279;  6'd31: oki_step = 11'd307;  6'd32: oki_step = 11'd337;
      6'd33: oki_step = 11'd371;  6'd34: oki_step = 11'd408;  6'd35: oki_step = 11'd449;
      6'd36: oki_step = 11'd494;  6'd37: oki_step = 11'd544;  6'd38: oki_step = 11'd598;
      6'd39: oki_step = 11'd658;  6'd40: oki_step = 11'd724;  6'd41: oki_step = 11'd796;
      6'd42: oki_step = 11'd876;  6'd43: oki_step = 11'd963;  6'd44: oki_step = 11'd1060;
      6'd45: oki_step = 11'd1166; 6'd46: oki_step = 11'd1282; 6'd47: oki_step = 11'd1411;
      default: oki_step = 11'd1552;
    endcase
  endfunction

  logic [6:0]         cnt   [NCH];
  logic [1:0]         sel_q [NCH];
  logic [3:0]         mem   [NCH][DEPTH];
  logic [AW:0]        wp    [NCH];
  logic [AW:0]        rp    [NCH];
  logic signed [11:0] acc   [NCH];
  logic [5:0]         idx   [NCH];
  logic [NCH-1:0]     pending;
  logic [PW-1:0]      ptr;
  logic               alive;   // holds din_ready low until the first clk after reset

  logic [NCH-1:0] stop, tick, full, empty, wr, svc;

  always_comb begin
    stop  = '0;
    tick  = '0;
    full  = '0;
    empty = '0;
    wr    = '0;
    svc   = '0;
    din_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      stop[i]  = (sel[2*i +: 2] == 2'd3);
      // A sel change restarts the divider, so no tick in that cycle.
      tick[i]  = cen && !stop[i] && (sel[2*i +: 2] == sel_q[i]) &&
                 (cnt[i] == div_last(sel[2*i +: 2]));
      empty[i] = (wp[i] == rp[i]);
      full[i]  = (wp[i][AW] != rp[i][AW]) && (wp[i][AW-1:0] == rp[i][AW-1:0]);
      din_ready[i] = alive && !full[i] && !stop[i];
      wr[i]    = din_valid[i] && din_ready[i];
      // A tick landing on the channel's own slot is served immediately.
      svc[i]   = (ptr == PW'(i)) && (pending[i] || tick[i]) && !stop[i];
    end
  end

  // Shared decode engine for the channel currently addressed by ptr.
  logic [3:0]         nib;
  logic [10:0]        step;
  logic [11:0]        delta;
  logic signed [13:0] sum;
  logic signed [11:0] acc_nx;
  logic signed [7:0]  idx_sum;
  logic [5:0]         idx_nx;

  always_comb begin
    nib   = mem[ptr][rp[ptr][AW-1:0]];
    step  = oki_step(idx[ptr]);
    delta = {4'd0, step[10:3]}
          + (nib[2] ? {1'b0, step}        : 12'd0)
          + (nib[1] ? {2'b0, step[10:1]}  : 12'd0)
          + (nib[0] ? {3'b0, step[10:2]}  : 12'd0);
    sum   = nib[3] ? ({{2{acc[ptr][11]}}, acc[ptr]} - $signed({2'b0, delta}))
                   : ({{2{acc[ptr][11]}}, acc[ptr]} + $signed({2'b0, delta}));
    if (sum > 14'sd2047)
      acc_nx = 12'sd2047;
    else if (sum < -14'sd2048)
      acc_nx = -12'sd2048;
    else
      acc_nx = sum[11:0];
    // adj = -1 for magnitudes 0..3, else 2*(m-3) = 2*(m[1:0]+1)
    idx_sum = $signed({2'b0, idx[ptr]}) +
              (nib[2] ? ($signed({4'b0, nib[1:0], 1'b0}) + 8'sd2) : -8'sd1);
    if (idx_sum < 8'sd0)
      idx_nx = 6'd0;
    else if (idx_sum > 8'sd48)
      idx_nx = 6'd48;
    else
      idx_nx = idx_sum[5:0];
  end

  // Nibble storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NCH; i++)
      if (wr[i]) mem[i][wp[i][AW-1:0]] <= din[4*i +: 4];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive    <= 1'b0;
      ptr      <= '0;
      pending  <= '0;
      sample   <= '0;
      underrun <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i]   <= 7'd0;
        sel_q[i] <= 2'd0;
        wp[i]    <= '0;
        rp[i]    <= '0;
        acc[i]   <= 12'sd0;
        idx[i]   <= 6'd0;
      end
    end else begin
      alive <= 1'b1;
      ptr   <= (ptr == PW'(NCH-1)) ? '0 : ptr + 1'b1;
      for (int i = 0; i < NCH; i++) begin
        sel_q[i]  <= sel[2*i +: 2];
        sample[i] <= 1'b0;

        if (stop[i] || (sel[2*i +: 2] != sel_q[i]))
          cnt[i] <= 7'd0;
        else if (cen)
          cnt[i] <= tick[i] ? 7'd0 : cnt[i] + 7'd1;

        if (wr[i]) wp[i] <= wp[i] + 1'b1;

        pending[i] <= (pending[i] | tick[i]) & ~svc[i];

        if (svc[i] && !empty[i]) begin
          rp[i]     <= rp[i] + 1'b1;
          acc[i]    <= acc_nx;
          idx[i]    <= idx_nx;
          sample[i] <= 1'b1;
        end

        // A new underrun beats a simultaneous clear.
        if (svc[i] && empty[i])
          underrun[i] <= 1'b1;
        else if (clr_udr[i])
          underrun[i] <= 1'b0;

        if (stop[i]) begin
          wp[i]      <= '0;
          rp[i]      <= '0;
          acc[i]     <= 12'sd0;
          idx[i]     <= 6'd0;
          pending[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign ch_sound[12*g +: 12] = acc[g];
  end

`ifdef JT5205_MIX_EN
  logic signed [MIXW-1:0] mix_sum;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NCH; i++)
      mix_sum = mix_sum + MIXW'(acc[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mix <= '0;
    else
      mix <= mix_sum;
  end
`else
  assign mix = '0;
`endif

endmodule

// File: tb/tb_jt5205_multi.sv
// tb/tb_jt5205_multi.sv - directed self-checking bench for jt5205_multi
module tb_jt5205_multi;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int MIXW  = 13;

  logic                clk;
  logic                rst_n;
  logic                cen;
  logic [2*NCH-1:0]    sel;
  logic [4*NCH-1:0]    din;
  logic [NCH-1:0]      din_valid;
  logic [NCH-1:0]      din_ready;
  logic [12*NCH-1:0]   ch_sound;
  logic [NCH-1:0]      sample;
  logic [NCH-1:0]      underrun;
  logic [NCH-1:0]      clr_udr;
  logic [MIXW-1:0]     mix;

  int total = 0;
  int bad   = 0;
  int s0q[$];
  int s1q[$];
  int t0q[$];
  int t1q[$];
  int fc;
  int fcen;

  jt5205_multi #(.NCH(NCH), .DEPTH(DEPTH), .MIXW(MIXW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .sel       (sel),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .ch_sound  (ch_sound),
    .sample    (sample),
    .underrun  (underrun),
    .clr_udr   (clr_udr),
    .mix       (mix)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cen: one clk high out of every four
  initial begin
    int phase;
    phase = 0;
    cen = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cen = (phase == 3);
      phase = (phase + 1) % 4;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int chv(input int ch);
    logic signed [11:0] v;
    v = ch_sound[12*ch +: 12];
    chv = int'(v);
  endfunction

  task automatic do_reset(input logic [1:0] s0, input logic [1:0] s1);
    rst_n = 1'b0;
    din_valid = '0;
    clr_udr = '0;
    din = '0;
    sel = {s1, s0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Writes exactly want0/want1 nibbles (n0/n1) as space allows and collects
  // the decoded samples until both channels produced that many.
  task automatic feed(input logic [3:0] n0, input logic [3:0] n1,
                      input int want0, input int want1, input int maxclk);
    int wr0;
    int wr1;
    wr0 = 0;
    wr1 = 0;
    s0q.delete(); s1q.delete(); t0q.delete(); t1q.delete();
    fc = 0;
    fcen = 0;
    din = {n1, n0};
    while (fc < maxclk && (s0q.size() < want0 || s1q.size() < want1)) begin
      @(posedge clk);
      #1;
      fc++;
      if (cen) fcen++;
      if (din_valid[0]) wr0++;
      if (din_valid[1]) wr1++;
      if (sample[0]) begin s0q.push_back(chv(0)); t0q.push_back(fc); end
      if (sample[1]) begin s1q.push_back(chv(1)); t1q.push_back(fc); end
      din_valid[0] = din_ready[0] && (wr0 < want0);
      din_valid[1] = din_ready[1] && (wr1 < want1);
    end
    din_valid = '0;
    chk("feed_count0", s0q.size(), want0);
    chk("feed_count1", s1q.size(), want1);
  endtask

  initial begin
    int sat_exp[8];
    int n;
    int cnt;
    int paired;
    int ok;
    sat_exp = '{30, 93, 229, 522, 1153, 2047, 2047, 2047};

    // Reset state
    rst_n = 1'b0;
    sel = {2'd3, 2'd0};
    din = '0;
    din_valid = '0;
    clr_udr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ch_sound", int'(ch_sound), 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_din_ready", int'(din_ready), 0);
    chk("rst_mix", int'(mix), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", int'(din_ready), 1);

    // First decode at /96: 0x7 -> 30, then 0xF -> -33
    feed(4'h7, 4'h0, 1, 0, 1000);
    chk("first_latency_ok", int'((fc + 1 >= 376) && (fc + 1 <= 392)), 1);
    chk("first_0x7", s0q[0], 30);
    chk("no_udr_first", int'(underrun[0]), 0);
    feed(4'hF, 4'h0, 1, 0, 1000);
    chk("second_0xF", s0q[0], -33);

    // Zero nibbles: +2 each, idx pinned at 0
    do_reset(2'd2, 2'd3);
    feed(4'h0, 4'h0, 8, 0, 3000);
    for (int k = 0; k < 8; k++) chk("zero_stream", s0q[k], 2 * (k + 1));

    // Positive saturation, then a 0x8 reveals idx = 48 (step 1552 -> delta 194)
    do_reset(2'd2, 2'd3);
    feed(4'h7, 4'h0, 8, 0, 3000);
    for (int k = 0; k < 8; k++) chk("sat_stream", s0q[k], sat_exp[k]);
    feed(4'h8, 4'h0, 1, 0, 1000);
    chk("idx_at_48", s0q[0], 1853);

    // Two channels: /48 and /96 ticking together
    do_reset(2'd2, 2'd0);
    feed(4'h0, 4'h0, 100, 50, 25000);
    chk("cen_per_tick0", fcen / 48, 100);
    chk("ch0_final", chv(0), 200);
    chk("ch1_final", chv(1), 100);
    chk("no_udr_stream", int'(underrun), 0);
    paired = 0;
    foreach (t1q[a]) begin
      ok = 0;
      foreach (t0q[b])
        if ((t0q[b] - t1q[a] <= NCH) && (t1q[a] - t0q[b] <= NCH)) ok = 1;
      paired += ok;
    end
    chk("paired_strobes", paired, 50);

    // ch1 drains -> underrun, value held, clear, overfill
    n = 0;
    while (!underrun[1] && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("udr1_set", int'(underrun[1]), 1);
    chk("udr1_hold", chv(1), 100);
    repeat (400) @(posedge clk);
    #1;
    chk("udr1_hold_late", chv(1), 100);
    clr_udr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr_udr[1] = 1'b0;
    chk("udr1_clr", int'(underrun[1]), 0);
    din_valid[1] = 1'b1;
    for (int k = 0; k < DEPTH + 1; k++) begin
      din[7:4] = (k == DEPTH) ? 4'h7 : 4'h0;
      @(posedge clk);
      #1;
      if (k == DEPTH - 1) chk("full_ready", int'(din_ready[1]), 0);
    end
    din_valid[1] = 1'b0;
    n = 0;
    cnt = 0;
    while (!underrun[1] && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (sample[1]) cnt++;
    end
    chk("drain_samples", cnt, DEPTH);
    chk("drain_value", chv(1), 108);

    // Both channels saturated, then ch1 stopped
    do_reset(2'd2, 2'd2);
    feed(4'h7, 4'h7, 7, 7, 5000);
    chk("sat0", s0q[6], 2047);
    chk("sat1", s1q[6], 2047);
    repeat (2) @(posedge clk);
    #1;
`ifdef JT5205_MIX_EN
    chk("mix_both", int'($signed(mix)), 4094);
`else
    chk("mix_off", int'(mix), 0);
`endif
    sel[3:2] = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("stop_ch1_zero", chv(1), 0);
    chk("stop_ch1_ready", int'(din_ready[1]), 0);
    chk("ch0_kept", chv(0), 2047);
`ifdef JT5205_MIX_EN
    chk("mix_one", int'($signed(mix)), 2047);
`else
    chk("mix_off_stop", int'(mix), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
